// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell is reused LSB-first over WIDTH cycles.
// A carry flop, operand shift registers, a bit counter and an IDLE/RUN/DONE FSM sequence the cell.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             s_d, carry_d;

    // The single full-adder cell, fed by the LSBs of the shift registers.
    always_comb begin
        s_d     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_d = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sr_q  <= a_i;
                        b_sr_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= carry_d;
                    sum_q   <= {s_d, sum_q[WIDTH-1:1]};
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here; requests are not queued.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: directed cases, randomized ops against
// plain-arithmetic reference, and an exhaustive WIDTH=3 back-to-back sweep.
module tb_serial_full_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8));

    serial_full_adder #(.WIDTH(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .a_i(a3), .b_i(b3), .cin_i(cin3),
        .busy_o(busy3), .done_o(done3), .sum_o(sum3), .cout_o(cout3));

    // Issue one WIDTH=8 op and wait (bounded) for done; inputs are scrambled after capture.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output int lat,
                       output int bc, output bit both);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        @(negedge clk);
        lat = 0; bc = 0; both = 1'b0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            if (busy8 && done8) both = 1'b1;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (busy8 && done8) both = 1'b1;
        s = sum8; co = cout8;
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b1; start3 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy8, done8, sum8, cout8} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, need all 0", busy8, done8, sum8, cout8);
        end
        rst = 1'b0; start8 = 1'b0; start3 = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stays_idle: got busy=%b done=%b busy3=%b, need 0", busy8, done8, busy3);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat, bc; bit both;
        op8(8'h3C, 8'h05, 1'b0, s, co, lat, bc, both);
        n_chk++;
        if ({co, s} !== 9'h041) begin n_fail++; $display("FAIL basic_sum: got %h/%b, need 41/0", s, co); end
        n_chk++;
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, need 8", lat); end
        n_chk++;
        if (bc !== 8 || both) begin n_fail++; $display("FAIL basic_busy: got busy cycles=%0d overlap=%b, need 8/0", bc, both); end
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cout8, sum8, done8} !== {1'b0, 8'h41, 1'b0}) begin
            n_fail++; $display("FAIL basic_hold: got sum=%h cout=%b done=%b, need 41/0/0", sum8, cout8, done8);
        end
    endtask

    task automatic test_carry_wrap();
        logic [7:0] s; logic co; int lat, bc; bit both;
        op8(8'hFF, 8'h01, 1'b0, s, co, lat, bc, both);
        n_chk++;
        if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL wrap_ff_01: got %h/%b, need 00/1", s, co); end
        op8(8'hFF, 8'hFF, 1'b1, s, co, lat, bc, both);
        n_chk++;
        if ({co, s} !== 9'h1FF) begin n_fail++; $display("FAIL wrap_ff_ff_1: got %h/%b, need FF/1", s, co); end
    endtask

    task automatic test_busy_protect();
        int n; int extra;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
        n = 0;
        while (!done8 && n < 40) begin @(negedge clk); n++; end
        n_chk++;
        if ({cout8, sum8} !== 9'h030 || !done8) begin
            n_fail++; $display("FAIL busy_protect_sum: got %h/%b done=%b, need 30/0/1", sum8, cout8, done8);
        end
        extra = 0;
        repeat (12) begin @(negedge clk); if (busy8 || done8) extra++; end
        n_chk++;
        if (extra !== 0) begin n_fail++; $display("FAIL busy_protect_no_queue: got %0d active cycles, need 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic co; int lat, bc; bit both; int dn;
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy8, done8, sum8, cout8} !== 11'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h cout=%b, need 0", busy8, done8, sum8, cout8);
        end
        rst = 1'b0;
        dn = 0;
        repeat (12) begin @(negedge clk); if (done8) dn++; end
        n_chk++;
        if (dn !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d done pulses, need 0", dn); end
        op8(8'h01, 8'h02, 1'b1, s, co, lat, bc, both);
        n_chk++;
        if ({co, s} !== 9'h004) begin n_fail++; $display("FAIL reset_mid_next_op: got %h/%b, need 04/0", s, co); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic c, co; int lat, bc; bit both; int unsigned ref_v;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            ref_v = int'(a) + int'(b) + int'(c);
            op8(a, b, c, s, co, lat, bc, both);
            n_chk++;
            if ({co, s} !== 9'(ref_v) || lat != 8 || bc != 8 || both) begin
                n_fail++;
                $display("FAIL random_op%0d: %h+%h+%b got %h/%b lat=%0d busy=%0d ov=%b, need %h lat=8 busy=8",
                         i, a, b, c, s, co, lat, bc, both, 9'(ref_v));
            end
        end
    endtask

    task automatic test_exhaustive_w3();
        int dones; int n; time t_prev, t_now; logic [3:0] ref_v;
        dones = 0; t_prev = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            a3 = 3'(i >> 4); b3 = 3'(i >> 1); cin3 = 1'(i); start3 = 1'b1;
            ref_v = 4'(a3) + 4'(b3) + 4'(cin3);
            @(posedge clk);
            #1 start3 = 1'b0;
            @(negedge clk);
            n = 0;
            while (!done3 && n < 20) begin @(negedge clk); n++; end
            if (done3) dones++;
            t_now = $time;
            n_chk++;
            if ({cout3, sum3} !== ref_v) begin
                n_fail++; $display("FAIL w3_sum_%0d: got %h, need %h", i, {cout3, sum3}, ref_v);
            end
            if (i > 0) begin
                n_chk++;
                if (t_now - t_prev != 50) begin
                    n_fail++; $display("FAIL w3_spacing_%0d: got %0t, need 50", i, t_now - t_prev);
                end
            end
            t_prev = t_now;
        end
        n_chk++;
        if (dones !== 128) begin n_fail++; $display("FAIL w3_done_count: got %0d, need 128", dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_wrap();
        test_busy_protect();
        test_reset_mid();
        test_random();
        test_exhaustive_w3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
